// File: rtl/input_checker.sv
// input_checker
//
// Checks the player's button presses, one 2-bit color at a time, against the
// packed color sequence that the display side has just played out. Armed once
// per round by StartInput; reports either RoundPass (every color matched in
// order) or RoundFail (wrong color or no press within TIMEOUT cycles).
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   Colors      packed sequence, color i in bits [2i+1:2i], i = 0..15
//   RoundLen    colors in this round, values above 16 clamp to 16
//   StartInput  single-cycle pulse that arms a round (only honoured when idle)
//   Buttons     synchronized player buttons, bit k = color code k
//   Busy        high from arm until the outcome pulse
//   ColorIn     code of the last accepted press
//   ColorValid  one-cycle pulse per accepted press
//   Position    colors matched so far this round
//   RoundPass   one-cycle pulse, full sequence matched
//   RoundFail   one-cycle pulse, mismatch or timeout
//
// All outputs are registered.

module input_checker #(
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Colors,
  input  logic [4:0]  RoundLen,
  input  logic        StartInput,
  input  logic [3:0]  Buttons,
  output logic        Busy,
  output logic [1:0]  ColorIn,
  output logic        ColorValid,
  output logic [4:0]  Position,
  output logic        RoundPass,
  output logic        RoundFail
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPress,
    StWaitRelease,
    StPass,
    StFail
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     colors_q, colors_d;
  logic [4:0]      len_q, len_d;
  logic [4:0]      pos_q, pos_d;
  logic [1:0]      color_in_q, color_in_d;
  logic            color_valid_q, color_valid_d;
  logic            busy_q, busy_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      btn_prev_q, btn_prev_d;

  logic            btn_onehot;
  logic [1:0]      btn_code;
  logic            press_ok;
  logic [1:0]      exp_code;

  // Encode the button vector; anything that is not exactly one-hot is ignored.
  always_comb begin
    btn_onehot = 1'b1;
    btn_code   = 2'd0;
    unique case (Buttons)
      4'b0001: btn_code = 2'd0;
      4'b0010: btn_code = 2'd1;
      4'b0100: btn_code = 2'd2;
      4'b1000: btn_code = 2'd3;
      default: btn_onehot = 1'b0;
    endcase
  end

  // Edge detection: a press needs an all-released sample on the cycle before,
  // so a held button (including one held while arming) is seen only once.
  assign press_ok = btn_onehot && (btn_prev_q == 4'b0000);

  // Expected color at the current position. Position is below 16 whenever
  // this is consulted, so the low four bits select the slot.
  assign exp_code = {colors_q[{pos_q[3:0], 1'b1}], colors_q[{pos_q[3:0], 1'b0}]};

  assign btn_prev_d = Buttons;

  always_comb begin
    state_d       = state_q;
    colors_d      = colors_q;
    len_d         = len_q;
    pos_d         = pos_q;
    color_in_d    = color_in_q;
    busy_d        = busy_q;
    color_valid_d = 1'b0;
    pass_d        = 1'b0;
    fail_d        = 1'b0;
    // Counter only runs in WAIT_PRESS, so every entry starts it from zero.
    cnt_d         = '0;

    unique case (state_q)
      StIdle: begin
        if (StartInput) begin
          colors_d = Colors;
          len_d    = (RoundLen > 5'd16) ? 5'd16 : RoundLen;
          pos_d    = 5'd0;
          busy_d   = 1'b1;
          state_d  = (RoundLen == 5'd0) ? StPass : StWaitPress;
        end
      end

      StWaitPress: begin
        // An accepted press wins over a timeout expiring on the same cycle.
        if (press_ok) begin
          color_in_d    = btn_code;
          color_valid_d = 1'b1;
          if (btn_code == exp_code) begin
            pos_d   = pos_q + 5'd1;
            state_d = StWaitRelease;
          end else begin
            state_d = StFail;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StFail;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWaitRelease: begin
        if (Buttons == 4'b0000) begin
          state_d = (pos_q == len_q) ? StPass : StWaitPress;
        end
      end

      StPass: begin
        pass_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      StFail: begin
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      colors_q      <= '0;
      len_q         <= '0;
      pos_q         <= '0;
      color_in_q    <= '0;
      color_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      cnt_q         <= '0;
      btn_prev_q    <= '0;
    end else begin
      state_q       <= state_d;
      colors_q      <= colors_d;
      len_q         <= len_d;
      pos_q         <= pos_d;
      color_in_q    <= color_in_d;
      color_valid_q <= color_valid_d;
      busy_q        <= busy_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      cnt_q         <= cnt_d;
      btn_prev_q    <= btn_prev_d;
    end
  end

  assign Busy       = busy_q;
  assign ColorIn    = color_in_q;
  assign ColorValid = color_valid_q;
  assign Position   = pos_q;
  assign RoundPass  = pass_q;
  assign RoundFail  = fail_q;

endmodule

// File: tb/tb_input_checker.sv
// Testbench for input_checker. Stimulus tasks describe rounds in player terms
// (arm, press a color after a gap, hold, release) and push the events the
// round must produce, stamped with the clock edge they belong to, into a
// queue. A separate monitor pops and compares whenever the DUT pulses
// ColorValid, RoundPass or RoundFail.

module tb_input_checker;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Colors;
  logic [4:0]  RoundLen;
  logic        StartInput;
  logic [3:0]  Buttons;
  logic        Busy;
  logic [1:0]  ColorIn;
  logic        ColorValid;
  logic [4:0]  Position;
  logic        RoundPass;
  logic        RoundFail;

  input_checker #(
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Colors    (Colors),
    .RoundLen  (RoundLen),
    .StartInput(StartInput),
    .Buttons   (Buttons),
    .Busy      (Busy),
    .ColorIn   (ColorIn),
    .ColorValid(ColorValid),
    .Position  (Position),
    .RoundPass (RoundPass),
    .RoundFail (RoundFail)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; an event stamped N appears right after edge N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // kind: 3'b001 ColorValid, 3'b010 RoundPass, 3'b100 RoundFail
  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic [1:0] color;
    logic [4:0] pos;
  } ev_t;

  ev_t exp_q[$];

  // Reference model of the round in progress.
  logic [31:0] lcolors;
  int          len;
  int          pos;
  int          wp_entry;  // edge on which the checker last began waiting for a press
  bit          over;

  function automatic void push_ev(input logic [2:0] k, input int c, input logic [1:0] col,
                                  input int p);
    ev_t e;
    e.kind  = k;
    e.cyc   = c;
    e.color = col;
    e.pos   = 5'(p);
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(Busy), 0);
    check({tag, "_colorin"}, int'(ColorIn), 0);
    check({tag, "_colorvalid"}, int'(ColorValid), 0);
    check({tag, "_position"}, int'(Position), 0);
    check({tag, "_roundpass"}, int'(RoundPass), 0);
    check({tag, "_roundfail"}, int'(RoundFail), 0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: compares every output pulse against the next expected event.
  initial begin : monitor
    ev_t        ev;
    logic [2:0] act;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_event: kind %b due at cycle %0d, not seen by cycle %0d",
                 ev.kind, ev.cyc, cyc);
      end
      act = {RoundFail, RoundPass, ColorValid};
      if (act != 3'b000) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: outputs %b at cycle %0d, expected none", act, cyc);
        end else begin
          ev = exp_q.pop_front();
          check("event_kind", int'(act), int'(ev.kind));
          check("event_cycle", cyc, ev.cyc);
          check("event_position", int'(Position), int'(ev.pos));
          if (ev.kind == 3'b001) begin
            check("event_colorin", int'(ColorIn), int'(ev.color));
            check("busy_on_valid", int'(Busy), 1);
          end else begin
            check("busy_after_outcome", int'(Busy), 0);
          end
        end
      end
    end
  end

  task automatic arm(input logic [31:0] c, input logic [4:0] rl);
    int e;
    Colors     = c;
    RoundLen   = rl;
    StartInput = 1'b1;
    e = cyc + 1;
    step();
    StartInput = 1'b0;
    // Later input changes must not disturb the latched round.
    Colors     = $urandom;
    RoundLen   = 5'($urandom);
    lcolors    = c;
    len        = (rl > 5'd16) ? 16 : int'(rl);
    pos        = 0;
    over       = 1'b0;
    wp_entry   = e;
    check("busy_after_arm", int'(Busy), 1);
    check("position_after_arm", int'(Position), 0);
    if (len == 0) begin
      push_ev(3'b010, e + 1, 2'd0, 0);
      over = 1'b1;
    end
  endtask

  // Press one color: optional rejected noise, gap idle cycles, hold cycles, release.
  task automatic press(input logic [1:0] code, input int gap, input int hold, input bit noise,
                       input bit poke);
    int p;
    int r;
    bit acc;
    bit match;
    if (over) return;
    if (noise) begin
      Buttons = 4'b0101;
      step();
      Buttons = 4'b0100;  // one-hot, but follows a non-zero sample
      step();
      Buttons = 4'b0000;
      step();
    end
    repeat (gap) step();
    Buttons = 4'(4'b0001 << code);
    p       = cyc + 1;
    acc     = (p <= wp_entry + int'(TO));
    match   = 1'b0;
    if (!acc) begin
      push_ev(3'b100, wp_entry + int'(TO) + 1, 2'd0, pos);
      over = 1'b1;
    end else begin
      match = (code == lcolors[2*pos +: 2]);
      if (match) begin
        pos++;
        push_ev(3'b001, p, code, pos);
      end else begin
        push_ev(3'b001, p, code, pos);
        push_ev(3'b100, p + 1, 2'd0, pos);
        over = 1'b1;
      end
      if (poke) begin
        // A start pulse during the round must be ignored.
        StartInput = 1'b1;
        Colors     = $urandom;
        RoundLen   = 5'd0;
      end
    end
    step();
    StartInput = 1'b0;
    repeat (hold - 1) step();
    Buttons = 4'b0000;
    r = cyc + 1;
    if (acc && match) begin
      if (pos == len) begin
        push_ev(3'b010, r + 1, 2'd0, pos);
        over = 1'b1;
      end else begin
        wp_entry = r;
      end
    end
    step();
  endtask

  task automatic wait_timeout();
    push_ev(3'b100, wp_entry + int'(TO) + 1, 2'd0, pos);
    over = 1'b1;
    while (cyc < wp_entry + int'(TO) + 2) step();
  endtask

  task automatic end_round();
    int k;
    k = 0;
    Buttons = 4'b0000;
    while (exp_q.size() > 0 && k < 4 * int'(TO)) begin
      step();
      k++;
    end
    check("events_drained", exp_q.size(), 0);
    exp_q.delete();
    step();
    step();
  endtask

  initial begin : stim
    logic [31:0] rc;
    logic [1:0]  code;
    int          rl;
    int          mode;
    int          stop;

    reset      = 1'b0;
    StartInput = 1'b0;
    Buttons    = 4'b0000;
    Colors     = 32'h0;
    RoundLen   = 5'd0;
    over       = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b1;
    step();

    // Full correct round with codes 0,1,2,3.
    arm(32'h0000_00E4, 5'd4);
    for (int i = 0; i < 4; i++) press(2'(i), 1, 2, 1'b0, 1'b0);
    end_round();
    check("position_held_idle", int'(Position), 4);
    check("colorin_held_idle", int'(ColorIn), 3);
    check("busy_idle", int'(Busy), 0);

    // Wrong second color.
    arm(32'h0000_00E4, 5'd4);
    press(2'd0, 1, 2, 1'b0, 1'b0);
    press(2'd3, 1, 2, 1'b0, 1'b0);
    end_round();
    check("position_after_fail", int'(Position), 1);
    check("colorin_after_fail", int'(ColorIn), 3);

    // Timeout with no press; press on the last allowed cycle; one cycle too late.
    arm(32'h0000_00E4, 5'd4);
    wait_timeout();
    end_round();
    arm(32'h0000_00E4, 5'd4);
    press(2'd0, int'(TO) - 1, 2, 1'b0, 1'b0);
    press(2'd1, 0, 1, 1'b0, 1'b0);
    press(2'd2, int'(TO) - 1, 3, 1'b0, 1'b0);
    press(2'd3, 0, 1, 1'b0, 1'b0);
    end_round();
    arm(32'h0000_00E4, 5'd4);
    press(2'd0, int'(TO), 2, 1'b0, 1'b0);
    end_round();

    // Multi-bit noise rejected; long hold gives one ColorValid.
    arm(32'h0000_00E4, 5'd2);
    press(2'd0, 0, 2, 1'b1, 1'b0);
    press(2'd1, 0, 50, 1'b0, 1'b0);
    end_round();

    // Zero length passes at once; length 20 clamps to 16.
    arm(32'h0000_00E4, 5'd0);
    end_round();
    rc = $urandom;
    arm(rc, 5'd20);
    for (int i = 0; i < 16; i++) press(lcolors[2*i +: 2], 0, 1, 1'b0, 1'b0);
    end_round();
    check("position_clamped", int'(Position), 16);

    // Reset mid-round at position 2.
    arm(32'h0000_00E4, 5'd4);
    press(2'd0, 1, 2, 1'b0, 1'b0);
    press(2'd1, 1, 2, 1'b0, 1'b0);
    check("position_before_reset", int'(Position), 2);
    reset = 1'b0;
    step();
    check_all_zero("midreset");
    check("no_events_pending_at_reset", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b1;
    over  = 1'b1;
    step();
    step();

    // Start pulse while busy is ignored.
    arm(32'h0000_00E4, 5'd4);
    press(2'd0, 1, 2, 1'b0, 1'b1);
    press(2'd1, 1, 2, 1'b0, 1'b1);
    press(2'd2, 0, 1, 1'b0, 1'b0);
    press(2'd3, 2, 2, 1'b0, 1'b0);
    end_round();

    // Button already held at arm is not accepted until re-pressed.
    Buttons = 4'b0001;
    step();
    arm(32'h0000_00E4, 5'd1);
    repeat (3) step();
    Buttons = 4'b0000;
    step();
    press(2'd0, 0, 2, 1'b0, 1'b0);
    end_round();

    // Randomized rounds: mostly correct, some wrong colors, some timeouts.
    for (int r = 0; r < 30; r++) begin
      rc   = $urandom;
      rl   = $urandom_range(0, 20);
      mode = $urandom_range(0, 7);
      arm(rc, 5'(rl));
      stop = (len > 0) ? $urandom_range(0, len - 1) : 0;
      for (int i = 0; i < len; i++) begin
        if (over) break;
        if (mode == 0 && i == stop) begin
          wait_timeout();
          break;
        end
        code = lcolors[2*i +: 2];
        if (mode == 1 && i == stop) code = code ^ 2'($urandom_range(1, 3));
        press(code, $urandom_range(0, 5), $urandom_range(1, 4),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      end
      end_round();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
